tick_pulse_gen: RTL
===================

# tick_pulse_gen

Downstream consumer of the fast clock divider: takes its single-cycle zero/terminal-count tick and turns it into a programmable-width output pulse (e.g. PPS-style or gate outputs). Supports armed/continuous and one-shot operation, output polarity inversion, a free-running tick counter and a sticky overrun flag for ticks that arrive while a pulse is still in progress.

## Interface

- `NBITS_WIDTH`, default 16: width of pulse-length register, in i_clk cycles.
- `NBITS_CNT`, default 32: width of tick event counter.

- `i_clk` input 1: single clock, same domain as the divider.
- `i_rst_n` input 1: reset, synchronous, active-low.
- `i_tick` input 1: single-cycle trigger, the divider's zero output.
- `i_arm` input 1: single-cycle request, enter ARMED.
- `i_disarm` input 1: single-cycle request, abort and return to IDLE.
- `i_oneshot` input 1: 1 = one pulse per arm; 0 = continuous. Sampled at each trigger.
- `i_width` input NBITS_WIDTH: pulse length in cycles. Latched at trigger.
- `i_invert` input 1: output polarity.
- `i_clr` input 1: clears tick counter and overrun flag.
- `o_out` output 1: pulse output after polarity, `o_pulse ^ i_invert`.
- `o_pulse` output 1: registered raw pulse.
- `o_armed` output 1: high in ARMED or PULSE.
- `o_overrun` output 1: sticky; set by a tick rejected during PULSE.
- `o_tick_count` output NBITS_CNT: ticks seen since reset/clear.

## Operation

- States: IDLE, ARMED, PULSE. Enum lives in the shared package.
- IDLE:
  - `i_arm` -> ARMED.
  - Ticks are counted only.
- ARMED:
  - A tick with latched width W ≥ 1 -> PULSE. The remaining-count register is loaded with W.
  - A tick with W = 0 produces no pulse. It is still counted. If `i_oneshot` = 1 the state -> IDLE; otherwise it stays ARMED.
- PULSE:
  - `o_pulse` = 1.
  - The remaining count decrements each cycle.
  - On the final high cycle (remaining = 1), behaviour depends on whether a tick is present:
    - Tick present: a seamless retrigger. The new width is latched and there is no low gap. This applies even when `i_oneshot` = 1, but only if the accepted pulse was started in continuous mode.
    - No tick: -> ARMED (continuous) or IDLE (one-shot).
  - A tick in any earlier PULSE cycle is ignored for triggering, sets `o_overrun`, and is counted.
- `i_disarm` has priority over everything except reset. From any state -> IDLE next cycle, and `o_pulse` drops next cycle.
- `i_arm` while already ARMED or PULSE: no effect.
- `i_arm` + `i_tick` in the same cycle in IDLE: arm only; the tick is not a trigger.
- Tick counter: increments on every `i_tick` regardless of state, and wraps modulo 2^NBITS_CNT.
- `i_clr`:
  - Zeroes `o_tick_count` and `o_overrun`.
  - `i_clr` + `i_tick` together: count = 1, `o_overrun` = 0.
  - `i_clr` does not affect the state machine.

## Timing

- Reset (`i_rst_n` = 0 at a clock edge):
  - State IDLE, `o_pulse` = 0, `o_armed` = 0, `o_overrun` = 0, `o_tick_count` = 0.
  - `o_out` = `i_invert`.
- Trigger latency: tick at cycle N (ARMED) -> `o_pulse` high on cycles N+1 … N+W, low at N+W+1 unless retriggered.
- `o_armed` rises the cycle after `i_arm`. It falls the cycle after `i_disarm`, or after the one-shot pulse's last high cycle.
- `o_overrun` is set the cycle after the offending tick.
- `o_tick_count` updates the cycle after the tick.
- Reset mid-pulse: the output is low on the next cycle and the state is IDLE.
- Width W = 2^NBITS_WIDTH − 1 is legal; no internal overflow.
- The divider period is assumed to be ≥ 1 cycle. A width-1 pulse with a tick every cycle gives `o_pulse` continuously high with no overrun.

## Structure

- Shared package holds:
  - the state enum (IDLE/ARMED/PULSE);
  - default width constants.
- One natural sub-module: `tick_event_ctr`, the clearable wrapping counter with clear-plus-increment handling.
- The FSM and width down-counter stay in the top module.

## Test plan

- Reset, `i_arm`, W = 5, tick at cycle 10 -> `o_pulse` high on cycles 11–15, `o_tick_count` = 1, `o_overrun` = 0.
- Continuous, W = 4, ticks every 4 cycles -> `o_pulse` stays high with no gap; the next tick arriving 2 cycles into a pulse sets `o_overrun` = 1.
- One-shot, W = 3, two ticks 10 cycles apart -> exactly one 3-cycle pulse; `o_armed` drops after it; `o_tick_count` = 2.
- `i_disarm` on the 2nd cycle of a W = 8 pulse -> `o_pulse` low on the next cycle, state IDLE; later ticks are counted only.
- W = 0 while armed, tick -> no pulse, count increments; `i_clr` with a simultaneous tick -> count = 1, overrun = 0.
- `i_invert` = 1 throughout reset and a W = 2 pulse -> `o_out` is 1 in reset and idle, 0 for exactly 2 cycles.

Source files
------------

// File: rtl/tick_pulse_gen_pkg.sv
// Shared types and default sizing for the tick-to-pulse generator.
package tick_pulse_gen_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPulse = 2'd2
  } tpg_state_e;

  localparam int unsigned DefaultNbitsWidth = 16;
  localparam int unsigned DefaultNbitsCnt   = 32;

endpackage

// File: rtl/tick_event_ctr.sv
// Clearable wrapping event counter; a clear coinciding with an event restarts the count at one.
module tick_event_ctr #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = Width'(inc_i);
    end else if (inc_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tick_pulse_gen.sv
// Turns a single-cycle divider tick into a programmable-width pulse with armed/one-shot control,
// polarity inversion, a free-running tick counter and a sticky overrun flag.
module tick_pulse_gen
  import tick_pulse_gen_pkg::*;
#(
  parameter int unsigned NBITS_WIDTH = DefaultNbitsWidth,
  parameter int unsigned NBITS_CNT   = DefaultNbitsCnt
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_tick,
  input  logic                   i_arm,
  input  logic                   i_disarm,
  input  logic                   i_oneshot,
  input  logic [NBITS_WIDTH-1:0] i_width,
  input  logic                   i_invert,
  input  logic                   i_clr,
  output logic                   o_out,
  output logic                   o_pulse,
  output logic                   o_armed,
  output logic                   o_overrun,
  output logic [NBITS_CNT-1:0]   o_tick_count
);

  tpg_state_e             state_q, state_d;
  logic [NBITS_WIDTH-1:0] rem_q, rem_d;
  logic                   os_q, os_d;
  logic                   overrun_q, overrun_d;
  logic                   width_nz, last_cycle, early_tick;

  assign width_nz   = |i_width;
  assign last_cycle = (rem_q == NBITS_WIDTH'(1));
  // A tick before the final high cycle cannot start a new pulse.
  assign early_tick = (state_q == StPulse) && !last_cycle && i_tick;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      os_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      os_q      <= os_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    os_d    = os_q;
    unique case (state_q)
      StIdle: begin
        if (i_arm) state_d = StArmed;
      end
      StArmed: begin
        if (i_tick) begin
          if (width_nz) begin
            state_d = StPulse;
            rem_d   = i_width;
            os_d    = i_oneshot;
          end else if (i_oneshot) begin
            state_d = StIdle;
          end
        end
      end
      StPulse: begin
        if (!last_cycle) begin
          rem_d = rem_q - NBITS_WIDTH'(1);
        end else if (i_tick && !os_q) begin
          // Seamless retrigger only for pulses started in continuous mode.
          if (width_nz) begin
            rem_d = i_width;
            os_d  = i_oneshot;
          end else begin
            state_d = i_oneshot ? StIdle : StArmed;
          end
        end else begin
          state_d = os_q ? StIdle : StArmed;
        end
      end
      default: state_d = StIdle;
    endcase
    if (i_disarm) state_d = StIdle;
  end

  always_comb begin
    overrun_d = overrun_q;
    if (early_tick) overrun_d = 1'b1;
    if (i_clr)      overrun_d = 1'b0;
  end

  always_comb begin
    o_pulse = (state_q == StPulse);
    o_armed = (state_q != StIdle);
  end

  assign o_out     = o_pulse ^ i_invert;
  assign o_overrun = overrun_q;

  tick_event_ctr #(
    .Width (NBITS_CNT)
  ) u_tick_event_ctr (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clr_i   (i_clr),
    .inc_i   (i_tick),
    .count_o (o_tick_count)
  );

endmodule
